seg_scan_decoder: RTL and testbench

- Reader for a multiplexed 7-segment display bus. It is the inverse of the team's binary-to-segment decoder.
- Samples segment and anode lines, filters glitches and scan transitions, and recovers a 4-bit hex value per digit.
- Used in loopback self-test of the display path and for monitoring external 7-seg drivers.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_scan_decoder_if.sv | 41 ++++
 rtl/seg2bin.sv | 21 ++
 rtl/seg_scan_decoder.sv | 157 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: glyph table, blank pattern and scan-reader FSM states.
// Segment patterns are abcdefg with segment a in the MSB.
package seg_pkg;
    localparam int SEG_W = 7;
    localparam int HEX_W = 4;

    localparam logic [SEG_W-1:0] BLANK = 7'b0000000;

    // Indexed by hex value; also used by the binary-to-segment encoder.
    localparam logic [SEG_W-1:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;
endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bus bundle for seg_scan_decoder: raw display lines in, recovered digits out.
// Optional decimal-point lines exist only when SEG_SCAN_DP_EN is defined.
interface seg_scan_decoder_if
    import seg_pkg::*;
#(
    parameter int NDIG = 4
);
    // sample_en is a one-cycle strobe with no back-pressure: the reader
    // consumes ca/seg/an (and dp) on every clock edge where sample_en=1.
    logic                ca;
    logic                sample_en;
    logic [1:7]          seg;
    logic [NDIG-1:0]     an;
    logic [4*NDIG-1:0]   dig_out;
    logic [NDIG-1:0]     dig_valid;
    logic [NDIG-1:0]     dig_err;
    logic                upd;
    state_t              state_dbg;
`ifdef SEG_SCAN_DP_EN
    logic                dp;
    logic [NDIG-1:0]     dig_dp;

    modport master (
        output ca, sample_en, seg, an, dp,
        input  dig_out, dig_valid, dig_err, upd, state_dbg, dig_dp
    );
    modport slave (
        input  ca, sample_en, seg, an, dp,
        output dig_out, dig_valid, dig_err, upd, state_dbg, dig_dp
    );
`else
    modport master (
        output ca, sample_en, seg, an,
        input  dig_out, dig_valid, dig_err, upd, state_dbg
    );
    modport slave (
        input  ca, sample_en, seg, an,
        output dig_out, dig_valid, dig_err, upd, state_dbg
    );
`endif
endinterface

// File: rtl/seg2bin.sv
// Combinational inverse glyph lookup: segment pattern -> {hit, blank, code}.
module seg2bin
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] pat,
    output logic             hit,
    output logic             blank,
    output logic [HEX_W-1:0] code
);
    always_comb begin
        hit   = 1'b0;
        code  = '0;
        blank = (pat == BLANK);
        for (int k = 0; k < 16; k++) begin
            if (!hit && pat == GLYPH[k]) begin
                hit  = 1'b1;
                code = k[HEX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment bus reader: debounces one-hot scan samples and latches a hex value per digit.
// Optional decimal-point capture is enabled by defining SEG_SCAN_DP_EN.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_decoder_if.slave bus
);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT + 1);
`ifdef SEG_SCAN_DP_EN
    localparam int PAT_W = SEG_W + 1;
`else
    localparam int PAT_W = SEG_W;
`endif

    logic [SEG_W-1:0]  s_norm;
    logic [NDIG-1:0]   a_norm;
    logic [PAT_W-1:0]  pat;
    logic [IDX_W-1:0]  idx;
    logic              one_hot;

    state_t            state, state_n;
    logic [IDX_W-1:0]  cand_idx, cand_idx_n;
    logic [PAT_W-1:0]  cand_pat, cand_pat_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              commit;

    logic [4*NDIG-1:0] out_q, out_n;
    logic [NDIG-1:0]   valid_q, valid_n;
    logic [NDIG-1:0]   err_q, err_n;
    logic [NDIG-1:0]   dp_q, dp_n;
    logic              upd_q, upd_n;

    logic              hit, blank;
    logic [HEX_W-1:0]  code;

    assign s_norm = bus.ca ? ~bus.seg : bus.seg;
    assign a_norm = bus.ca ? ~bus.an  : bus.an;
`ifdef SEG_SCAN_DP_EN
    assign pat    = {bus.ca ? ~bus.dp : bus.dp, s_norm};
`else
    assign pat    = s_norm;
`endif
    assign one_hot = $onehot(a_norm);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (a_norm[i]) idx = i[IDX_W-1:0];
        end
    end

    seg2bin u_seg2bin (
        .pat   (s_norm),
        .hit   (hit),
        .blank (blank),
        .code  (code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cand_idx <= '0;
            cand_pat <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            cand_idx <= cand_idx_n;
            cand_pat <= cand_pat_n;
            cnt      <= cnt_n;
        end
    end

    // A change of digit or pattern always restarts the run at count 1.
    always_comb begin
        state_n    = state;
        cand_idx_n = cand_idx;
        cand_pat_n = cand_pat;
        cnt_n      = cnt;
        commit     = 1'b0;
        if (bus.sample_en) begin
            if (!one_hot) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else if (state != IDLE && idx == cand_idx && pat == cand_pat) begin
                if (state == TRACK) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt_n == CNT_W'(STABLE_CNT)) begin
                        commit  = 1'b1;
                        state_n = LOCKED;
                    end
                end
            end else begin
                cand_idx_n = idx;
                cand_pat_n = pat;
                cnt_n      = CNT_W'(1);
                if (STABLE_CNT == 1) begin
                    commit  = 1'b1;
                    state_n = LOCKED;
                end else begin
                    state_n = TRACK;
                end
            end
        end
    end

    always_comb begin
        out_n   = out_q;
        valid_n = valid_q;
        err_n   = err_q;
        dp_n    = dp_q;
        if (commit) begin
            if (hit) begin
                out_n[idx*HEX_W +: HEX_W] = code;
                valid_n[idx] = 1'b1;
                err_n[idx]   = 1'b0;
            end else begin
                valid_n[idx] = 1'b0;
                err_n[idx]   = !blank;
            end
`ifdef SEG_SCAN_DP_EN
            dp_n[idx] = pat[SEG_W];
`endif
        end
        upd_n = commit && ({out_n, valid_n, err_n, dp_n} != {out_q, valid_q, err_q, dp_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= '0;
            err_q   <= '0;
            dp_q    <= '0;
            upd_q   <= 1'b0;
        end else begin
            out_q   <= out_n;
            valid_q <= valid_n;
            err_q   <= err_n;
            dp_q    <= dp_n;
            upd_q   <= upd_n;
        end
    end

    assign bus.dig_out   = out_q;
    assign bus.dig_valid = valid_q;
    assign bus.dig_err   = err_q;
    assign bus.upd       = upd_q;
    assign bus.state_dbg = state;
`ifdef SEG_SCAN_DP_EN
    assign bus.dig_dp    = dp_q;
`endif
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed table-driven bench for seg_scan_decoder (NDIG=4, STABLE_CNT=4).
module tb_seg_scan_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_decoder_if #(.NDIG(4)) bus ();

    seg_scan_decoder #(.NDIG(4), .STABLE_CNT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic        ca;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        en;
        logic [15:0] e_out;
        logic [3:0]  e_val;
        logic [3:0]  e_err;
        logic        e_upd;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic ca, input logic [3:0] an,
                                input logic [6:0] seg, input logic en, input logic [15:0] e_out,
                                input logic [3:0] e_val, input logic [3:0] e_err, input logic e_upd);
        vec_t v;
        v.name = name; v.ca = ca; v.an = an; v.seg = seg; v.en = en;
        v.e_out = e_out; v.e_val = e_val; v.e_err = e_err; v.e_upd = e_upd;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic ca, input logic [3:0] an, input logic [6:0] seg, input logic en);
        @(negedge clk);
        bus.ca        = ca;
        bus.an        = an;
        bus.seg       = seg;
        bus.sample_en = en;
`ifdef SEG_SCAN_DP_EN
        bus.dp        = ca;
`endif
    endtask

    task automatic check_outs(input string name, input logic [15:0] e_out, input logic [3:0] e_val,
                              input logic [3:0] e_err, input logic e_upd);
        check({name, ".dig_out"},   32'(bus.dig_out),   32'(e_out));
        check({name, ".dig_valid"}, 32'(bus.dig_valid), 32'(e_val));
        check({name, ".dig_err"},   32'(bus.dig_err),   32'(e_err));
        check({name, ".upd"},       32'(bus.upd),       32'(e_upd));
    endtask

    task automatic step(input vec_t v);
        drive(v.ca, v.an, v.seg, v.en);
        @(posedge clk);
        #1;
        check_outs(v.name, v.e_out, v.e_val, v.e_err, v.e_upd);
    endtask

    initial begin
        bus.ca = 1'b0; bus.an = '0; bus.seg = '0; bus.sample_en = 1'b0;
`ifdef SEG_SCAN_DP_EN
        bus.dp = 1'b0;
`endif
        // Digit 0 shows '0' on a common-cathode bus; only the 4th strobe commits.
        for (int i = 0; i < 3; i++) add("t1_track", 0, 4'b0001, 7'h7E, 1, 16'h0000, 4'h0, 4'h0, 0);
        add("t1_commit", 0, 4'b0001, 7'h7E, 1, 16'h0000, 4'h1, 4'h0, 1);
        add("t1_locked", 0, 4'b0001, 7'h7E, 1, 16'h0000, 4'h1, 4'h0, 0);
        // Common-anode: an=1011 selects digit 2, seg=1001111 inverts to '1'.
        for (int i = 0; i < 3; i++) add("t2_track", 1, 4'b1011, 7'h4F, 1, 16'h0000, 4'h1, 4'h0, 0);
        add("t2_commit", 1, 4'b1011, 7'h4F, 1, 16'h0100, 4'h5, 4'h0, 1);
        // Glitch on digit 0: 8,8,8,0,8,8,8 never commits; one more 8 does.
        add("t3_g0", 0, 4'b0001, 7'h7F, 1, 16'h0100, 4'h5, 4'h0, 0);
        add("t3_g1", 0, 4'b0001, 7'h7F, 1, 16'h0100, 4'h5, 4'h0, 0);
        add("t3_g2", 0, 4'b0001, 7'h7F, 1, 16'h0100, 4'h5, 4'h0, 0);
        add("t3_g3", 0, 4'b0001, 7'h7E, 1, 16'h0100, 4'h5, 4'h0, 0);
        add("t3_g4", 0, 4'b0001, 7'h7F, 1, 16'h0100, 4'h5, 4'h0, 0);
        add("t3_g5", 0, 4'b0001, 7'h7F, 1, 16'h0100, 4'h5, 4'h0, 0);
        add("t3_g6", 0, 4'b0001, 7'h7F, 1, 16'h0100, 4'h5, 4'h0, 0);
        add("t3_commit", 0, 4'b0001, 7'h7F, 1, 16'h0108, 4'h5, 4'h0, 1);
        // Digit 1: '5' then the illegal pattern 1010101.
        for (int i = 0; i < 3; i++) add("t4_five", 0, 4'b0010, 7'h5B, 1, 16'h0108, 4'h5, 4'h0, 0);
        add("t4_five_commit", 0, 4'b0010, 7'h5B, 1, 16'h0158, 4'h7, 4'h0, 1);
        for (int i = 0; i < 3; i++) add("t4_bad", 0, 4'b0010, 7'h55, 1, 16'h0158, 4'h7, 4'h0, 0);
        add("t4_bad_commit", 0, 4'b0010, 7'h55, 1, 16'h0158, 4'h5, 4'h2, 1);
        // Multi-hot and no-hot anodes never qualify.
        for (int i = 0; i < 10; i++) add("t5_multi", 0, 4'b0011, 7'h7F, 1, 16'h0158, 4'h5, 4'h2, 0);
        for (int i = 0; i < 10; i++) add("t5_none", 0, 4'b0000, 7'h7F, 1, 16'h0158, 4'h5, 4'h2, 0);
        // sample_en=0 gaps freeze the run count without resetting it.
        add("t6_s1", 0, 4'b0001, 7'h7E, 1, 16'h0158, 4'h5, 4'h2, 0);
        add("t6_s2", 0, 4'b0001, 7'h7E, 1, 16'h0158, 4'h5, 4'h2, 0);
        for (int i = 0; i < 3; i++) add("t6_hold", 0, 4'b0001, 7'h7E, 0, 16'h0158, 4'h5, 4'h2, 0);
        add("t6_s3", 0, 4'b0001, 7'h7E, 1, 16'h0158, 4'h5, 4'h2, 0);
        add("t6_commit", 0, 4'b0001, 7'h7E, 1, 16'h0150, 4'h5, 4'h2, 1);
        // BLANK on an already-invalid digit changes nothing, so no upd.
        for (int i = 0; i < 4; i++) add("t7_blank3", 0, 4'b1000, 7'h00, 1, 16'h0150, 4'h5, 4'h2, 0);
        // BLANK on digit 2 clears valid but keeps its value.
        for (int i = 0; i < 3; i++) add("t7_blank2", 0, 4'b0100, 7'h00, 1, 16'h0150, 4'h5, 4'h2, 0);
        add("t7_blank2_commit", 0, 4'b0100, 7'h00, 1, 16'h0150, 4'h1, 4'h2, 1);

        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 16'h0, 4'h0, 4'h0, 0);
        check("reset.state", 32'(bus.state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[n]) step(vecs[n]);

        // Asynchronous reset after two matching strobes discards the run.
        for (int i = 0; i < 2; i++) begin
            drive(0, 4'b1000, 7'h79, 1);
            @(posedge clk); #1;
            check_outs("t8_pre", 16'h0150, 4'h1, 4'h2, 0);
        end
        #2 rst = 1'b1;
        #1;
        check_outs("t8_rst", 16'h0, 4'h0, 4'h0, 0);
        check("t8_rst.state", 32'(bus.state_dbg), 32'd0);
        @(negedge clk);
        bus.sample_en = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'b1000, 7'h79, 1);
            @(posedge clk); #1;
            check_outs("t8_post", 16'h0, 4'h0, 4'h0, 0);
        end
        drive(0, 4'b1000, 7'h79, 1);
        @(posedge clk); #1;
        check_outs("t8_commit", 16'h3000, 4'h8, 4'h0, 1);
        drive(0, 4'b1000, 7'h79, 0);
        @(posedge clk); #1;
        check_outs("t8_idle", 16'h3000, 4'h8, 4'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
